// File: rtl/alu_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_pkg
//   Shared definitions for the ALU-control decoder and the execution unit:
//   ALU operation codes and the execution FSM state encoding.
// -----------------------------------------------------------------------------
package alu_exec_unit_pkg;

    // ALU operation codes (3-bit alu_ctrl). 100 and 111 are unused and
    // execute as ADD.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;

    // Execution FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_ops.sv
// -----------------------------------------------------------------------------
// alu_comb_ops
//   Purely combinational single-cycle ALU operations: ADD, SUB, AND, OR, SLT.
//   Any code not listed (including SLL, which the parent handles) yields ADD.
// Ports
//   a, b      in   WIDTH  operands
//   alu_ctrl  in   3      operation code
//   result    out  WIDTH  operation result
// -----------------------------------------------------------------------------
module alu_comb_ops
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = a + b;  // ADD and all unlisted codes; carry out dropped
        case (alu_ctrl)
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            // Signed compare, result zero-extended to full width
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execution end of the ALU-control interface. Accepts an op code and two
//   operands over a valid/ready handshake and returns a registered result and
//   zero flag. ADD/SUB/AND/OR/SLT take one cycle; SLL shifts one bit per cycle
//   (latency max(1, shamt)) unless ALU_FAST_SHIFT_EN is defined, in which case
//   a barrel shifter makes every op single-cycle.
// Configuration macro
//   ALU_FAST_SHIFT_EN  barrel-shift SLL; SHIFT state and counter removed
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      op/operands valid
//   in_ready   out  1      unit idle and able to accept
//   alu_ctrl   in   3      operation code
//   a          in   WIDTH  operand A (shift source for SLL)
//   b          in   WIDTH  operand B (low SHAMT_W bits = shift amount for SLL)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  registered result
//   zero       out  1      registered result==0
// -----------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic               accept;
    logic               is_sll;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   comb_res;
    logic [WIDTH-1:0]   load_val;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_sll    = (alu_ctrl == ALU_SLL);
    assign shamt     = b[SHAMT_W-1:0];

    alu_comb_ops #(.WIDTH(WIDTH)) u_comb_ops (
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .result   (comb_res)
    );

`ifdef ALU_FAST_SHIFT_EN
    // Value registered at the accept edge
    always_comb begin
        load_val = comb_res;
        if (is_sll) load_val = a << shamt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                result <= load_val;
                zero   <= (load_val == '0);
            end
        end
    end
`else
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   shift_nxt;

    // The first bit of an SLL is shifted at the accept edge, so only
    // shamt-1 further SHIFT cycles are needed.
    always_comb begin
        load_val = comb_res;
        if (is_sll) load_val = (shamt != '0) ? (a << 1) : a;
    end

    assign shift_nxt = {result[WIDTH-2:0], 1'b0};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = (is_sll && shamt > SHAMT_W'(1)) ? ST_SHIFT : ST_DONE;
            end
            // cnt==1 here means this edge performs the last shift
            ST_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)          state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // result doubles as the shift accumulator; it is not observable until DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                result <= load_val;
                zero   <= (load_val == '0);
                cnt    <= shamt - SHAMT_W'(1);
            end else if (state == ST_SHIFT) begin
                result <= shift_nxt;
                zero   <= (shift_nxt == '0);
                cnt    <= cnt - SHAMT_W'(1);
            end
        end
    end
`endif

endmodule
